// File: rtl/ifetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
// Entry layout and word-alignment helper used by top and FIFO.
package ifetch_queue_pkg;

  localparam int          IFQ_DEPTH    = 4;
  localparam int          IFQ_MAX_OUTS = 2;
  localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: DEPTH-entry FIFO of {pc, inst} with sync flush.
// Ports: flush_i/push_i/pop_i, wdata_i in, rdata_o head, count_o, empty_o.
module ifq_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  ifq_entry_t    wdata_i,
  input  logic          pop_i,
  output ifq_entry_t    rdata_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  ifq_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: nothing is read until count says so.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  a_no_push_full: assert property (
    @(posedge clk) disable iff (!rst)
    !(push_i && full && !flush_i)
  );

  a_no_pop_empty: assert property (
    @(posedge clk) disable iff (!rst)
    !(pop_i && empty_o && !flush_i)
  );

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential fetch + DEPTH-deep {pc,inst} buffer to decode.
// Ports: redirect/redirect_pc/pause in; imem_* handshake; inst_valid/inst/inst_pc out.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = IFQ_DEPTH,
  parameter int          MAX_OUTS = IFQ_MAX_OUTS,
  parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        pause,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int OW = $clog2(MAX_OUTS + 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [OW-1:0] outs_q, outs_d;
  logic [OW-1:0] disc_q, disc_d;
  logic [CW-1:0] count;
  logic          empty;
  logic          grant;
  logic          drop;
  logic          push;
  logic          pop;
  ifq_entry_t    head;
  ifq_entry_t    wentry;
  logic [31:0]   tgt_pc;

  assign tgt_pc = word_align(redirect_pc);

  // Outstanding requests reserve a slot, so a push never finds it full.
  assign imem_req = !redirect
                 && (int'(outs_q) < MAX_OUTS)
                 && (int'(count) + int'(outs_q) < DEPTH);
  assign imem_addr = fetch_pc_q;

  assign grant = imem_req && imem_gnt;
  assign drop  = imem_rvalid && (disc_q != '0);
  assign push  = imem_rvalid && (disc_q == '0) && !redirect;
  assign pop   = inst_valid && !pause && !redirect;

  assign wentry.pc   = resp_pc_q;
  assign wentry.inst = imem_rdata;

  assign inst_valid = !empty;
  assign inst       = inst_valid ? head.inst : INST_NOP;
  assign inst_pc    = inst_valid ? head.pc : 32'h0;

  always_comb begin
    outs_d = outs_q;
    if (grant)       outs_d = outs_d + 1'b1;
    if (imem_rvalid) outs_d = outs_d - 1'b1;
  end

  // On redirect every request still unanswered belongs to the old stream.
  always_comb begin
    disc_d = disc_q;
    if (redirect)  disc_d = outs_d;
    else if (drop) disc_d = disc_q - 1'b1;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (redirect) begin
      fetch_pc_d = tgt_pc;
      resp_pc_d  = tgt_pc;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)  resp_pc_d  = resp_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outs_q     <= '0;
      disc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outs_q     <= outs_d;
      disc_q     <= disc_d;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count),
    .empty_o (empty)
  );

  a_rvalid_outs: assert property (
    @(posedge clk) disable iff (!rst)
    imem_rvalid |-> (outs_q != '0)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: memory model + in-order scoreboard.
// Expected {pc,inst} pushed on accepted responses, popped on consume.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        pause = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .MAX_OUTS (MAXO),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pause       (pause),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  req_t        pend[$];
  exp_t        sb[$];
  exp_t        plog[$];
  int          pcyc[$];
  int          cyc = 0;
  int          epoch = 0;
  int          lat = 1;
  logic        gnt_en = 1'b1;
  logic [31:0] exp_fetch = '0;
  int          ntot = 0;
  int          npass = 0;
  int          nfail = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    req_t r;
    bit   rv;
    bit   ereq;
    rv = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem(pend[0].addr) : 32'h0;
    imem_gnt    = gnt_en;
    #1;
    ereq = !redirect && (pend.size() < MAXO)
        && (sb.size() + pend.size() < DEPTH);
    chk("req", imem_req, ereq);
    chk("valid", inst_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      chk("pc", inst_pc, sb[0].pc);
      chk("inst", inst, sb[0].inst);
    end else begin
      chk("pc_idle", inst_pc, 32'h0);
      chk("inst_idle", inst, 32'h0);
    end
    if (imem_req) chk("addr", imem_addr, exp_fetch);
    if (redirect) begin
      sb.delete();
      epoch++;
      exp_fetch = {redirect_pc[31:2], 2'b00};
      if (rv) void'(pend.pop_front());
    end else begin
      if (inst_valid && !pause && sb.size() != 0) begin
        plog.push_back(sb[0]);
        pcyc.push_back(cyc);
        void'(sb.pop_front());
      end
      if (rv) begin
        r = pend.pop_front();
        if (r.epoch == epoch) sb.push_back('{r.addr, mem(r.addr)});
      end
    end
    if (imem_req && imem_gnt) begin
      pend.push_back('{exp_fetch, epoch, cyc + lat});
      exp_fetch = exp_fetch + 32'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rc;
    int k;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_req", imem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    cyc = 1;

    // Back-to-back fetch, one-cycle memory
    repeat (8) step();
    chk("tp_npop", plog.size(), 6);
    if (plog.size() >= 6) begin
      for (int i = 0; i < 4; i++) begin
        chk("tp_pc", plog[i].pc, 32'(4 * i));
        chk("tp_cyc", pcyc[i], 3 + i);
      end
    end

    // Decode stall fills the queue
    pause = 1'b1;
    repeat (10) step();
    chk("stall_req", imem_req, 1'b0);
    chk("stall_valid", inst_valid, 1'b1);
    chk("stall_pc", inst_pc, 32'h18);
    chk("stall_inst", inst, mem(32'h18));
    pause = 1'b0;
    repeat (6) step();
    chk("rel_npop", plog.size(), 12);
    if (plog.size() >= 10) begin
      for (int i = 0; i < 4; i++) begin
        chk("rel_pc", plog[6 + i].pc, 32'h18 + 32'(4 * i));
        chk("rel_cyc", pcyc[6 + i], 19 + i);
      end
    end

    // Redirect with two requests in flight
    lat = 2;
    k = 0;
    while (pend.size() != 2 && k < 20) begin
      step();
      k++;
    end
    chk("outs2_bound", k < 20, 1'b1);
    n = plog.size();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    chk("rd_valid", inst_valid, 1'b0);
    repeat (8) step();
    chk("rd_npop", plog.size() >= n + 2, 1'b1);
    if (plog.size() >= n + 2) begin
      chk("rd_pc0", plog[n].pc, 32'h100);
      chk("rd_pc1", plog[n + 1].pc, 32'h104);
    end

    // Redirect coinciding with response and pop
    lat = 1;
    repeat (4) step();
    k = 0;
    while (!(sb.size() != 0 && pend.size() != 0
             && pend[0].due <= cyc) && k < 20) begin
      step();
      k++;
    end
    chk("coin_bound", k < 20, 1'b1);
    n = plog.size();
    rc = cyc;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    chk("coin_valid", inst_valid, 1'b0);
    chk("coin_addr", imem_addr, 32'h200);
    repeat (5) step();
    chk("coin_npop", plog.size() > n, 1'b1);
    if (plog.size() > n) begin
      chk("coin_pc", plog[n].pc, 32'h200);
      chk("coin_cyc", pcyc[n], rc + 3);
    end

    // Randomized grants/stalls/redirects
    for (int i = 0; i < 300; i++) begin
      gnt_en = 1'($urandom_range(0, 3) != 0);
      pause = 1'($urandom_range(0, 3) == 0);
      lat = $urandom_range(1, 3);
      redirect = 1'($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      step();
    end
    redirect = 1'b0;
    pause = 1'b0;
    gnt_en = 1'b1;
    lat = 1;

    // Reset mid-stream with three entries held
    pause = 1'b1;
    k = 0;
    while (sb.size() < 3 && k < 20) begin
      step();
      k++;
    end
    chk("mid_bound", k < 20, 1'b1);
    chk("mid_valid_pre", inst_valid, 1'b1);
    rst = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    chk("mid_valid", inst_valid, 1'b0);
    chk("mid_inst", inst, 32'h0);
    chk("mid_pc", inst_pc, 32'h0);
    chk("mid_addr", imem_addr, 32'h0);
    pend.delete();
    sb.delete();
    epoch++;
    exp_fetch = 32'h0;
    pause = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc = 1;

    // Grant withheld: address must stay put
    step();
    step();
    gnt_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("gnt_hold", imem_addr, 32'h8);
    end
    gnt_en = 1'b1;
    step();
    chk("gnt_adv", imem_addr, 32'hC);
    repeat (6) step();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
